// File: rtl/qam_stream_mapper_if.sv
`default_nettype none
// ============================================================================
// Module      : qam_stream_mapper_if
// Description : Coded-bit input handshake and constellation-point output
//               handshake of the streaming QAM mapper.
// Revision    : 1.0 - initial release
// ============================================================================
interface qam_stream_mapper_if #(
  parameter int IQ_W = 16
);
  logic                   bit_in;
  logic                   bit_valid;
  logic                   bit_ready;
  logic [1:0]             mod_sel;
  logic signed [IQ_W-1:0] i_out;
  logic signed [IQ_W-1:0] q_out;
  logic                   sym_valid;
  logic                   sym_ready;
  logic [5:0]             sc_idx;
  logic                   last;

  // Environment view: feeds bits and mode, consumes points.
  modport master (
    output bit_in, bit_valid, mod_sel, sym_ready,
    input  bit_ready, i_out, q_out, sym_valid, sc_idx, last
  );

  // Mapper view.
  modport slave (
    input  bit_in, bit_valid, mod_sel, sym_ready,
    output bit_ready, i_out, q_out, sym_valid, sc_idx, last
  );
endinterface
`default_nettype wire

// File: rtl/qam_stream_mapper.sv
`default_nettype none
// ============================================================================
// Module      : qam_stream_mapper
// Description : Groups coded bits into 1/2/4/6-bit groups and emits Gray-coded
//               BPSK/QPSK/16-QAM/64-QAM points with subcarrier index.
//               Optional macro MAPPER_NORM_EN scales levels by the modulation
//               normalisation factor K in Q2.(IQ_W-2) (K values given for
//               IQ_W=16, shifted left for wider outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module qam_stream_mapper #(
  parameter int IQ_W = 16,
  parameter int NSD  = 48
) (
  input  wire logic          clk,
  input  wire logic          rst,
  qam_stream_mapper_if.slave bus
);

  localparam logic [1:0] MOD_BPSK  = 2'd0;
  localparam logic [1:0] MOD_QPSK  = 2'd1;
  localparam logic [1:0] MOD_QAM16 = 2'd2;
  localparam logic [5:0] SC_LAST   = 6'(NSD - 1);

`ifdef MAPPER_NORM_EN
  localparam int K_SHIFT = IQ_W - 16;
  localparam logic signed [IQ_W-1:0] K_BPSK  = IQ_W'(16384 << K_SHIFT);
  localparam logic signed [IQ_W-1:0] K_QPSK  = IQ_W'(11585 << K_SHIFT);
  localparam logic signed [IQ_W-1:0] K_QAM16 = IQ_W'(5181 << K_SHIFT);
  localparam logic signed [IQ_W-1:0] K_QAM64 = IQ_W'(2528 << K_SHIFT);
`endif

  // Single bit: 1 -> +1, 0 -> -1.
  function automatic logic signed [3:0] lvl1(input logic b);
    return b ? 4'sd1 : -4'sd1;
  endfunction

  // Two-bit Gray pair (b0 first).
  function automatic logic signed [3:0] lvl2(input logic [1:0] b);
    case (b)
      2'b00:   return -4'sd3;
      2'b01:   return -4'sd1;
      2'b11:   return 4'sd1;
      default: return 4'sd3;
    endcase
  endfunction

  // Three-bit Gray triple (b0 first).
  function automatic logic signed [3:0] lvl3(input logic [2:0] b);
    case (b)
      3'b000:  return -4'sd7;
      3'b001:  return -4'sd5;
      3'b011:  return -4'sd3;
      3'b010:  return -4'sd1;
      3'b110:  return 4'sd1;
      3'b111:  return 4'sd3;
      3'b101:  return 4'sd5;
      default: return 4'sd7;
    endcase
  endfunction

  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [5:0]             bits_q, bits_d;
  logic [1:0]             mode_q, mode_d;
  logic [5:0]             asm_idx_q, asm_idx_d;
  logic [5:0]             sc_idx_q, sc_idx_d;
  logic                   sym_valid_q, sym_valid_d;
  logic signed [IQ_W-1:0] i_q, i_d, q_q, q_d;

  logic                   w_first;
  logic [1:0]             w_mode;
  logic [2:0]             w_cnt_max;
  logic                   w_bit_ready;
  logic                   w_xfer;
  logic                   w_grp_done;
  logic                   w_accept;
  logic [5:0]             w_bits;
  logic signed [3:0]      w_lvl_i, w_lvl_q;
  logic signed [IQ_W-1:0] w_i_val, w_q_val;

  // Handshake and group control; the mode is taken live from mod_sel on the
  // very first bit of a symbol so a BPSK first bit maps correctly.
  always_comb begin
    w_first = (bit_cnt_q == 3'd0) && (asm_idx_q == 6'd0);
    w_mode  = w_first ? bus.mod_sel : mode_q;
    case (w_mode)
      MOD_BPSK:  w_cnt_max = 3'd0;
      MOD_QPSK:  w_cnt_max = 3'd1;
      MOD_QAM16: w_cnt_max = 3'd3;
      default:   w_cnt_max = 3'd5;
    endcase
    w_bit_ready = !((bit_cnt_q == w_cnt_max) && sym_valid_q && !bus.sym_ready);
    w_xfer      = bus.bit_valid && w_bit_ready;
    w_grp_done  = w_xfer && (bit_cnt_q == w_cnt_max);
    w_accept    = sym_valid_q && bus.sym_ready;
    w_bits      = bits_q;
    w_bits[bit_cnt_q] = bus.bit_in;
  end

  // Map the completed group to I/Q levels and optional normalisation.
  always_comb begin
    w_lvl_i = 4'sd0;
    w_lvl_q = 4'sd0;
    case (w_mode)
      MOD_BPSK:  w_lvl_i = lvl1(w_bits[0]);
      MOD_QPSK: begin
        w_lvl_i = lvl1(w_bits[0]);
        w_lvl_q = lvl1(w_bits[1]);
      end
      MOD_QAM16: begin
        w_lvl_i = lvl2({w_bits[0], w_bits[1]});
        w_lvl_q = lvl2({w_bits[2], w_bits[3]});
      end
      default: begin
        w_lvl_i = lvl3({w_bits[0], w_bits[1], w_bits[2]});
        w_lvl_q = lvl3({w_bits[3], w_bits[4], w_bits[5]});
      end
    endcase
`ifdef MAPPER_NORM_EN
    case (w_mode)
      MOD_BPSK: begin
        w_i_val = IQ_W'(w_lvl_i) * K_BPSK;
        w_q_val = IQ_W'(w_lvl_q) * K_BPSK;
      end
      MOD_QPSK: begin
        w_i_val = IQ_W'(w_lvl_i) * K_QPSK;
        w_q_val = IQ_W'(w_lvl_q) * K_QPSK;
      end
      MOD_QAM16: begin
        w_i_val = IQ_W'(w_lvl_i) * K_QAM16;
        w_q_val = IQ_W'(w_lvl_q) * K_QAM16;
      end
      default: begin
        w_i_val = IQ_W'(w_lvl_i) * K_QAM64;
        w_q_val = IQ_W'(w_lvl_q) * K_QAM64;
      end
    endcase
`else
    w_i_val = IQ_W'(w_lvl_i);
    w_q_val = IQ_W'(w_lvl_q);
`endif
  end

  // Next-state for counters, mode latch and the single-entry output register.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    bits_d      = bits_q;
    mode_d      = mode_q;
    asm_idx_d   = asm_idx_q;
    sc_idx_d    = sc_idx_q;
    sym_valid_d = sym_valid_q;
    i_d         = i_q;
    q_d         = q_q;
    if (w_xfer) begin
      bits_d    = w_bits;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (w_first) mode_d = bus.mod_sel;
    end
    if (w_accept) begin
      sym_valid_d = 1'b0;
      sc_idx_d    = (sc_idx_q == SC_LAST) ? 6'd0 : sc_idx_q + 6'd1;
    end
    // A completing group always finds the register free (bit_ready ensures it).
    if (w_grp_done) begin
      bit_cnt_d   = 3'd0;
      asm_idx_d   = (asm_idx_q == SC_LAST) ? 6'd0 : asm_idx_q + 6'd1;
      sym_valid_d = 1'b1;
      i_d         = w_i_val;
      q_d         = q_val_sel(w_q_val);
    end
  end

  function automatic logic signed [IQ_W-1:0] q_val_sel(input logic signed [IQ_W-1:0] v);
    return v;
  endfunction

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= 3'd0;
      bits_q      <= 6'd0;
      mode_q      <= MOD_BPSK;
      asm_idx_q   <= 6'd0;
      sc_idx_q    <= 6'd0;
      sym_valid_q <= 1'b0;
      i_q         <= '0;
      q_q         <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      bits_q      <= bits_d;
      mode_q      <= mode_d;
      asm_idx_q   <= asm_idx_d;
      sc_idx_q    <= sc_idx_d;
      sym_valid_q <= sym_valid_d;
      i_q         <= i_d;
      q_q         <= q_d;
    end
  end

  assign bus.bit_ready = w_bit_ready;
  assign bus.sym_valid = sym_valid_q;
  assign bus.i_out     = i_q;
  assign bus.q_out     = q_q;
  assign bus.sc_idx    = sc_idx_q;
  assign bus.last      = (sc_idx_q == SC_LAST);

endmodule
`default_nettype wire
